// File: rtl/ps2_host_tx_if.sv
// PS/2 transmit request/status bundle between the command source and ps2_host_tx.
// master: issues tx_data/tx_valid; slave: returns tx_ready, busy, done, ack_err, timeout.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, ack_err, timeout
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, ack_err, timeout
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// Ports: clk, reset (async low), bus (slave), raw line inputs, open-drain line enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic         clk,
  input  logic         reset,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] I_PRE = IW'(INHIBIT_CYCLES - 2);
  localparam logic [IW-1:0] I_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, SEND, WAIT_ACK, WAIT_IDLE
  } state_t;

  state_t        state;
  logic [2:0]    csync;
  logic [1:0]    dsync;
  logic [8:0]    shreg;
  logic [3:0]    nbit;
  logic [IW-1:0] icnt;
  logic [TW-1:0] tcnt;
  logic          nack_q;
  logic          c_fall;
  logic          active;

  // csync[2] is the edge-history stage behind the 2-FF synchronizer
  assign c_fall = ~csync[1] & csync[2];
  assign active = (state == SEND) || (state == WAIT_ACK) ||
                  (state == WAIT_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csync <= 3'b111;
      dsync <= 2'b11;
    end else begin
      csync <= {csync[1:0], ps2_clk_in};
      dsync <= {dsync[0], ps2_data_in};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      bus.tx_ready <= 1'b1;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.ack_err  <= 1'b0;
      bus.timeout  <= 1'b0;
      ps2_clk_oe   <= 1'b0;
      ps2_data_oe  <= 1'b0;
      shreg        <= '0;
      nbit         <= '0;
      icnt         <= '0;
      tcnt         <= '0;
      nack_q       <= 1'b0;
    end else begin
      bus.done    <= 1'b0;
      bus.ack_err <= 1'b0;
      bus.timeout <= 1'b0;
      if (active && tcnt == T_LAST) begin
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        bus.timeout <= 1'b1;
        state       <= IDLE;
      end else begin
        if (active) tcnt <= tcnt + TW'(1);
        unique case (state)
          IDLE: begin
            // ready/busy settle one cycle after done or timeout
            bus.tx_ready <= 1'b1;
            bus.busy     <= 1'b0;
            if (bus.tx_valid && bus.tx_ready) begin
              shreg        <= {~^bus.tx_data, bus.tx_data};
              nbit         <= '0;
              icnt         <= '0;
              bus.tx_ready <= 1'b0;
              bus.busy     <= 1'b1;
              ps2_clk_oe   <= 1'b1;
              state        <= INHIBIT;
            end
          end
          INHIBIT: begin
            icnt <= icnt + IW'(1);
            // start bit goes low in the last inhibit cycle
            if (icnt == I_PRE) ps2_data_oe <= 1'b1;
            if (icnt == I_LAST) begin
              ps2_clk_oe <= 1'b0;
              tcnt       <= '0;
              state      <= SEND;
            end
          end
          SEND: begin
            if (c_fall) begin
              nbit <= nbit + 4'd1;
              if (nbit == 4'd9) begin
                ps2_data_oe <= 1'b0;
                state       <= WAIT_ACK;
              end else begin
                ps2_data_oe <= ~shreg[0];
                shreg       <= {1'b0, shreg[8:1]};
              end
            end
          end
          WAIT_ACK: begin
            if (c_fall) begin
              nack_q <= dsync[1];
              state  <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            if (csync[1] && dsync[1]) begin
              bus.done    <= 1'b1;
              bus.ack_err <= nack_q;
              state       <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain device model.
// Table vectors, randomized frames, and hand sequences for timeout/hold/reset.
module tb_ps2_host_tx;
  localparam int INH = 40;
  localparam int TMO = 1500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic ps2_clk_oe, ps2_data_oe;
  logic ps2_clk_in, ps2_data_in;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx_if bus();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // start, 8 data LSB first, odd parity, stop
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    f = {1'b1, 1'b0, d, 1'b0};
    f[9] = (($countones(d) % 2) == 0);
    return f;
  endfunction

  int run = 0, rise_idx = 0, inh_len = 0, done_cnt = 0;
  logic prev_coe = 1'b0, prev_doe = 1'b0;
  always @(negedge clk) begin
    if (ps2_clk_oe) begin
      if (!prev_coe) begin
        run = 0;
        rise_idx = 0;
      end
      run++;
      if (ps2_data_oe && !prev_doe && rise_idx == 0) rise_idx = run;
    end else if (prev_coe) begin
      inh_len = run;
    end
    if (bus.done) done_cnt++;
    prev_coe = ps2_clk_oe;
    prev_doe = ps2_data_oe;
  end

  int dev_falls = 0;
  bit dev_abort = 0;

  // device: samples each bit while clock is high, just before the fall
  task automatic dev_frame(input bit nack, input int h,
                           output logic [10:0] bits);
    int n;
    bits = '0;
    dev_falls = 0;
    n = 0;
    while (!(ps2_clk_in && !ps2_data_in) && n < 4 * INH) begin
      @(negedge clk);
      n++;
    end
    chk("dev_request_seen", 32'(n < 4 * INH), 1);
    for (int i = 0; i < 11; i++) begin
      repeat (h) @(negedge clk);
      if (dev_abort) break;
      bits[i] = ps2_data_in;
      if (i == 10 && !nack) dev_data_low = 1'b1;
      dev_clk_low = 1'b1;
      dev_falls++;
      repeat (h) @(negedge clk);
      dev_clk_low = 1'b0;
    end
    if (dev_data_low) begin
      repeat (h) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input bit nack,
                           input bit exp_err, input int h,
                           input bit skip_req, input bit hold,
                           output logic [10:0] bits);
    int n;
    if (!skip_req) begin
      @(negedge clk);
      bus.tx_data = d;
      bus.tx_valid = 1'b1;
      n = 0;
      while (!bus.tx_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("accept_ready", 32'(bus.tx_ready), 1);
      @(negedge clk);
    end
    if (hold) begin
      bus.tx_data = 8'h55;
    end else begin
      bus.tx_valid = 1'b0;
      bus.tx_data = 8'($urandom);
    end
    chk("busy_after_accept", 32'(bus.busy), 1);
    dev_frame(nack, h, bits);
    chk("inhibit_len", 32'(inh_len), INH);
    chk("data_oe_rise_idx", 32'(rise_idx), INH);
    chk("frame_bits", 32'(bits), 32'(model_frame(d)));
    n = 0;
    while (!bus.done && n < 20 * h) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(bus.done), 1);
    chk("ack_err", 32'(bus.ack_err), 32'(exp_err));
    chk("done_lines_free", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    @(negedge clk);
    chk("done_width", 32'(bus.done), 0);
    chk("ready_after_done", 32'(bus.tx_ready), 1);
    chk("busy_after_done", 32'(bus.busy), 0);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         nack;
    int         h;
    bit         exp_par;
    bit         exp_err;
  } vec_t;

  vec_t vt[5];
  logic [10:0] rbits, rbits2;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int n, k, dc;
    vt[0] = '{8'hFF, 1'b0, 12, 1'b1, 1'b0};
    vt[1] = '{8'hF4, 1'b0, 9, 1'b0, 1'b0};
    vt[2] = '{8'h00, 1'b1, 15, 1'b1, 1'b1};
    vt[3] = '{8'h81, 1'b0, 20, 1'b1, 1'b0};
    vt[4] = '{8'h7F, 1'b1, 8, 1'b0, 1'b1};

    reset = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.tx_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_flags", {29'd0, bus.done, bus.ack_err, bus.timeout}, 0);
    chk("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", 32'(bus.tx_ready), 1);

    for (int i = 0; i < 5; i++) begin
      run_frame(vt[i].d, vt[i].nack, vt[i].exp_err, vt[i].h,
                1'b0, 1'b0, rbits);
      chk("table_parity", 32'(rbits[9]), 32'(vt[i].exp_par));
    end

    for (int r = 0; r < 6; r++) begin
      logic [7:0] d;
      bit nk;
      d = 8'($urandom);
      nk = bit'($urandom_range(0, 1));
      run_frame(d, nk, nk, $urandom_range(8, 25), 1'b0, 1'b0, rbits);
    end

    // silent device: abort exactly TMO cycles after clock release
    dc = done_cnt;
    @(negedge clk);
    bus.tx_data = 8'hF4;
    bus.tx_valid = 1'b1;
    n = 0;
    while (!bus.tx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.tx_valid = 1'b0;
    n = 0;
    while (ps2_clk_oe && n < 2 * INH) begin
      @(negedge clk);
      n++;
    end
    k = 0;
    while (!bus.timeout && k < TMO + 50) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_latency", 32'(k), TMO);
    chk("timeout_lines_free", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    chk("timeout_no_done", 32'(bus.done), 0);
    @(negedge clk);
    chk("timeout_width", 32'(bus.timeout), 0);
    chk("timeout_ready", 32'(bus.tx_ready), 1);
    chk("timeout_done_count", 32'(done_cnt - dc), 0);

    // tx_valid held with 0x55 during an 0xFF frame
    run_frame(8'hFF, 1'b0, 1'b0, 10, 1'b0, 1'b1, rbits);
    @(negedge clk);
    chk("hold_accept_busy", 32'(bus.busy), 1);
    chk("hold_accept_ready", 32'(bus.tx_ready), 0);
    run_frame(8'h55, 1'b0, 1'b0, 11, 1'b1, 1'b0, rbits2);

    // reset mid-frame after falling edge 5
    fork
      dev_frame(1'b0, 10, rbits);
      begin
        @(negedge clk);
        bus.tx_data = 8'hFF;
        bus.tx_valid = 1'b1;
        n = 0;
        while (!bus.tx_ready && n < 20) begin
          @(negedge clk);
          n++;
        end
        @(negedge clk);
        bus.tx_valid = 1'b0;
        n = 0;
        while (dev_falls < 5 && n < 4000) begin
          @(negedge clk);
          n++;
        end
        chk("reached_fall5", 32'(dev_falls >= 5), 1);
        repeat (4) @(negedge clk);
        chk("mid_frame_busy", 32'(bus.busy), 1);
        #2 reset = 1'b0;
        #1;
        chk("reset_oe_now", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        dev_abort = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
      end
    join
    dev_abort = 0;
    @(negedge clk);
    chk("after_reset_ready", 32'(bus.tx_ready), 1);
    chk("after_reset_busy", 32'(bus.busy), 0);
    chk("after_reset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
